// File: rtl/conv_window_sequencer_if.sv
// Tap stream between the window sequencer and the downstream MAC.
// The sequencer drives address and window tags, the MAC drives ready.
interface conv_window_sequencer_if #(
  parameter int ADDR_BITS  = 10,
  parameter int COORD_BITS = 5
);
  logic                  ready;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  addr_valid;
  logic                  acc_clear;
  logic                  acc_last;
  logic [COORD_BITS-1:0] out_row;
  logic [COORD_BITS-1:0] out_col;

  modport master (
    input  ready,
    output rd_addr,
    output addr_valid,
    output acc_clear,
    output acc_last,
    output out_row,
    output out_col
  );

  modport slave (
    output ready,
    input  rd_addr,
    input  addr_valid,
    input  acc_clear,
    input  acc_last,
    input  out_row,
    input  out_col
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks every KxK window of an IMG_H x IMG_W frame, one tap per
// accepted cycle, emitting pixel read addresses and window tags.
module conv_window_sequencer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int ADDR_BITS  = 10,
  parameter int COORD_BITS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  conv_window_sequencer_if.master tap,
  output logic busy,
  output logic done
);

  localparam int KB = (K > 1) ? $clog2(K) : 1;
  localparam logic [KB-1:0] K_MAX = KB'(K - 1);
  localparam logic [COORD_BITS-1:0] C_MAX =
    COORD_BITS'(IMG_W - K);
  localparam logic [COORD_BITS-1:0] R_MAX =
    COORD_BITS'(IMG_H - K);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [KB-1:0]         kc_q, kc_d;
  logic [KB-1:0]         kr_q, kr_d;
  logic [COORD_BITS-1:0] col_q, col_d;
  logic [COORD_BITS-1:0] row_q, row_d;

  logic                  valid_d;
  logic                  clear_d;
  logic                  last_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [COORD_BITS-1:0] orow_d;
  logic [COORD_BITS-1:0] ocol_d;

  logic accept;
  logic end_kc, end_kr, end_col, end_row;

  assign accept  = tap.addr_valid & tap.ready;
  assign end_kc  = (kc_q == K_MAX);
  assign end_kr  = (kr_q == K_MAX);
  assign end_col = (col_q == C_MAX);
  assign end_row = (row_q == R_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      kc_q           <= '0;
      kr_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      tap.rd_addr    <= '0;
      tap.addr_valid <= 1'b0;
      tap.acc_clear  <= 1'b0;
      tap.acc_last   <= 1'b0;
      tap.out_row    <= '0;
      tap.out_col    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      kc_q           <= kc_d;
      kr_q           <= kr_d;
      col_q          <= col_d;
      row_q          <= row_d;
      tap.rd_addr    <= addr_d;
      tap.addr_valid <= valid_d;
      tap.acc_clear  <= clear_d;
      tap.acc_last   <= last_d;
      tap.out_row    <= orow_d;
      tap.out_col    <= ocol_d;
      busy           <= valid_d;
      done           <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          kc_d    = '0;
          kr_d    = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // Carry chain: kc fastest, then kr, col, row.
          priority case (1'b1)
            !end_kc: kc_d = kc_q + 1'b1;
            !end_kr: begin
              kc_d = '0;
              kr_d = kr_q + 1'b1;
            end
            !end_col: begin
              kc_d  = '0;
              kr_d  = '0;
              col_d = col_q + 1'b1;
            end
            !end_row: begin
              kc_d  = '0;
              kr_d  = '0;
              col_d = '0;
              row_d = row_q + 1'b1;
            end
            default: state_d = DONE;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == RUN);
    clear_d = valid_d && (kc_d == '0) && (kr_d == '0);
    last_d  = valid_d && (kc_d == K_MAX) && (kr_d == K_MAX);
    orow_d  = valid_d ? row_d : '0;
    ocol_d  = valid_d ? col_d : '0;
    addr_d  = '0;
    if (valid_d) begin
      addr_d = ADDR_BITS'(
        (32'(row_d) + 32'(kr_d)) * 32'(IMG_W)
        + 32'(col_d) + 32'(kc_d));
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 28x28 frame, K=3.
// Walks whole frames against nested expected loops.
module tb_conv_window_sequencer;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KK = 3;
  localparam int AB = 10;
  localparam int CB = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  conv_window_sequencer_if #(
    .ADDR_BITS(AB),
    .COORD_BITS(CB)
  ) tap ();

  conv_window_sequencer #(
    .IMG_W(W),
    .IMG_H(H),
    .K(KK),
    .ADDR_BITS(AB),
    .COORD_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tap(tap.master),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int a_tab[10] = '{0, 1, 2, 28, 29, 30, 56, 57, 58, 1};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return {7'd0, done, busy, tap.addr_valid,
            tap.acc_clear, tap.acc_last,
            tap.out_row, tap.out_col, tap.rd_addr};
  endfunction

  function automatic logic [31:0] tap_vec(int r, int c,
                                          int i, int j);
    logic [9:0] a;
    a = 10'((r + i) * W + c + j);
    return {7'd0, 1'b0, 1'b1, 1'b1,
            1'(i == 0 && j == 0),
            1'(i == KK - 1 && j == KK - 1),
            5'(r), 5'(c), a};
  endfunction

  task automatic first_window(input string tag);
    start     = 1'b1;
    tap.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check({tag, "_addr"}, 32'(tap.rd_addr), a_tab[k]);
      check({tag, "_flags"},
            32'({tap.addr_valid, tap.acc_clear,
                 tap.acc_last, tap.out_col}),
            32'({1'b1, 1'(k == 0 || k == 9),
                 1'(k == 8), 5'(k == 9)}));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_frame(input string tag,
                           input bit stall,
                           input bit noise,
                           input int abort_at);
    int taps   = 0;
    int busy_n = 0;
    int stalls = 0;
    start     = 1'b1;
    tap.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r <= H - KK; r++)
    for (int c = 0; c <= W - KK; c++)
    for (int i = 0; i < KK; i++)
    for (int j = 0; j < KK; j++) begin
      if (taps == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_rst_out"}, obs(), 32'd0);
        rst = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check({tag, "_rst_idle"}, obs(), 32'd0);
        end
        return;
      end
      if (busy) busy_n++;
      check({tag, "_tap"}, obs(), tap_vec(r, c, i, j));
      if (r == 1 && c == 0 && i == 0 && j == 0)
        check({tag, "_row_wrap"},
              32'({tap.out_row, tap.out_col,
                   tap.rd_addr, tap.acc_clear}),
              32'({5'd1, 5'd0, 10'd28, 1'b1}));
      if (r == H - KK && c == W - KK &&
          i == KK - 1 && j == KK - 1)
        check({tag, "_last"},
              32'({tap.out_row, tap.out_col,
                   tap.rd_addr, tap.acc_last}),
              32'({5'd25, 5'd25, 10'd783, 1'b1}));
      if (stall && r == 0 && c == 0 && i == 1 && j == 1) begin
        tap.ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          stalls++;
          if (busy) busy_n++;
          check({tag, "_hold"}, obs(), tap_vec(r, c, i, j));
        end
        tap.ready = 1'b1;
      end
      start = noise && ((taps % 211) == 5);
      taps++;
      @(negedge clk);
    end
    start = noise;
    check({tag, "_done"},
          32'({done, busy, tap.addr_valid}), 32'(3'b100));
    check({tag, "_busy_n"}, busy_n, 6084 + stalls);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check({tag, "_idle"}, obs(), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    tap.ready = 1'b0;
    rst       = 1'b0;
    start     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", obs(), 32'd0);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle", obs(), 32'd0);
    first_window("win0");
    run_frame("frame", 1'b0, 1'b0, -1);
    run_frame("stall", 1'b1, 1'b1, -1);
    run_frame("abort", 1'b0, 1'b0, 500);
    first_window("restart");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMG_W, 28, input feature-map width in pixels
- IMG_H, 28, input feature-map height in pixels
- K, 3, square kernel size
- ADDR_BITS, 10, pixel address width; must satisfy 2^ADDR_BITS >= IMG_W*IMG_H
- COORD_BITS, 5, output row/col width; must hold max(IMG_W,IMG_H)-K
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, synchronous active-low reset
- start, in, 1, request a full-frame pass; sampled only in IDLE
- ready, in, 1, downstream MAC accepts current tap when ready=1 and addr_valid=1
- rd_addr, out, ADDR_BITS, pixel buffer read address of current tap
- addr_valid, out, 1, rd_addr and tags valid
- acc_clear, out, 1, current tap is first tap (kr=0, kc=0) of a window
- acc_last, out, 1, current tap is last tap (kr=K-1, kc=K-1) of a window
- out_row, out, COORD_BITS, output row of current window
- out_col, out, COORD_BITS, output column of current window
- busy, out, 1, high in RUN
- done, out, 1, one-cycle pulse after the last tap of the frame is accepted
REQ-003 Clock SHALL be clk; reset SHALL be synchronous, active-low, on port rst.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-005 IDLE with start=1 SHALL enter RUN next cycle with kc=kr=col=row=0, addr_valid=1, rd_addr=0, acc_clear=1.
REQ-006 start SHALL be ignored in RUN and DONE.
REQ-007 A tap SHALL be accepted on a cycle with addr_valid=1 and ready=1.
REQ-008 With addr_valid=1 and ready=0, rd_addr, acc_clear, acc_last, out_row and out_col SHALL hold unchanged.
REQ-009 On acceptance, counters SHALL advance in nested order: kc fastest (0..K-1), then kr (0..K-1), then col (0..IMG_W-K), then row (0..IMG_H-K); each wraps to 0 and carries to the next.
REQ-010 rd_addr SHALL equal (row+kr)*IMG_W + (col+kc), computed without truncation below ADDR_BITS.
REQ-011 acc_clear SHALL be high iff kr=0 and kc=0; acc_last SHALL be high iff kr=K-1 and kc=K-1; with K=1 both SHALL be high on every tap.
REQ-012 Acceptance of the tap with row=IMG_H-K, col=IMG_W-K, kr=kc=K-1 SHALL move RUN to DONE; addr_valid SHALL be 0 from the next cycle.
REQ-013 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in that cycle SHALL be ignored.
REQ-014 Total accepted taps per frame SHALL be (IMG_H-K+1)*(IMG_W-K+1)*K*K; no tap SHALL be skipped or repeated.
REQ-015 Throughput SHALL be one tap per cycle while ready=1, with no bubbles at window, row or frame-internal boundaries.

Reset
REQ-016 rst=0 on a clock edge SHALL force IDLE, clear all counters, and drive addr_valid, acc_clear, acc_last, busy and done to 0, and rd_addr, out_row and out_col to 0.
REQ-017 Reset asserted mid-RUN SHALL abort the frame with no done pulse; a subsequent start SHALL begin from tap 0.
REQ-018 start SHALL be ignored in any cycle with rst=0.

Verification
REQ-019 Basic: defaults, start pulse, ready=1 -> first window addresses 0,1,2,28,29,30,56,57,58; acc_clear on addr 0, acc_last on addr 58; second window starts at addr 1 with out_col=1.
REQ-020 Frame end: ready=1 throughout -> 6084 accepted taps; last window out_row=25, out_col=25, addresses 725..783 with last addr 783; done pulses once, exactly 1 cycle after the last acceptance; busy is high for 6084 cycles.
REQ-021 Stall: ready=0 for 3 cycles while rd_addr=29 -> rd_addr held at 29 with no tag change; the next accepted tap is 30.
REQ-022 Row wrap: after window (0,25) is accepted -> next tap has out_row=1, out_col=0, rd_addr=28, acc_clear=1, with no bubble.
REQ-023 Reset mid-run: rst=0 at tap 500 -> next cycle all outputs 0, state IDLE, no done; a restart reproduces the REQ-019 sequence.
REQ-024 Ignored start: start pulses during RUN and in the DONE cycle -> tap sequence unchanged, one done per frame, state IDLE after DONE.
